input_check: RTL

//  Player-input stage directly downstream of the LED pattern display stage. Once display ends
//  (enable rises), it captures the 16-step, 3-bit/step pattern and level. It debounces the 8
//  raw player buttons and compares each accepted press to the next pattern step, in order.

---
 rtl/input_check.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/input_check.sv
// input_check: player-input stage of the memory game.
// On an enable rise it latches the 16-step, 3-bit pattern and the round length
// derived from level. It then debounces the eight buttons and matches each
// accepted press, in order, against the next pattern step.
// Ports:
//   clk_1        in   1   only clock
//   rst          in   1   synchronous, active-high reset
//   enable       in   1   round active; low aborts to IDLE
//   level        in   3   difficulty, sampled on enable rise
//   pattern_flat in   48  step k at [3k+2:3k], sampled on enable rise
//   btn          in   8   raw buttons, btn[j] encodes step value j
//   led          out  8   debounced buttons while waiting for release, else 0
//   press_count  out  5   correct presses accepted this round
//   check_pass   out  1   high while in PASS
//   check_fail   out  1   high while in FAIL
module input_check #(
  parameter int unsigned DEBOUNCE_CYC = 200,
  parameter int unsigned TIMEOUT_CYC  = 50000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  level,
  input  logic [47:0] pattern_flat,
  input  logic [7:0]  btn,
  output logic [7:0]  led,
  output logic [4:0]  press_count,
  output logic        check_pass,
  output logic        check_fail
);

  localparam int unsigned NUM_BTN = 8;
  localparam int unsigned STEPS   = 16;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PRESS, S_WAIT_RELEASE, S_PASS, S_FAIL
  } state_t;

  state_t state, state_d;

  logic [DB_W-1:0]  db_cnt [NUM_BTN];
  logic [7:0]       db, db_d, db_prev;
  logic [TMO_W-1:0] tmo_cnt;
  logic             enable_prev;
  logic [STEPS-1:0][STEP_W-1:0] pattern_q;
  logic [CNT_W-1:0] seq_len_q;

  logic [7:0]       led_d;
  logic [CNT_W-1:0] press_count_d;
  logic             check_pass_d, check_fail_d;
  logic             capture_c;

  logic             enable_rise_c, press_evt_c, release_evt_c, extra_bit_c;
  logic             step_match_c, timeout_c;
  logic [STEP_W-1:0] step_c;
  logic [CNT_W-1:0] seq_len_c;

  // Per-bit debounce: a bit flips once the raw input has disagreed for DEBOUNCE_CYC samples.
  always_comb begin
    db_d = db;
    for (int unsigned j = 0; j < NUM_BTN; j++) begin
      if ((btn[j] != db[j]) && (db_cnt[j] == DB_LAST)) db_d[j] = ~db[j];
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      for (int unsigned j = 0; j < NUM_BTN; j++) db_cnt[j] <= '0;
      db      <= '0;
      db_prev <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_BTN; j++) begin
        if ((btn[j] == db[j]) || (db_cnt[j] == DB_LAST)) db_cnt[j] <= '0;
        else db_cnt[j] <= db_cnt[j] + DB_W'(1);
      end
      db      <= db_d;
      db_prev <= db;
    end
  end

  // Event decode on the debounced vector.
  assign enable_rise_c = enable && !enable_prev;
  assign press_evt_c   = (db_prev == '0) && (db != '0);
  assign release_evt_c = (db_prev != '0) && (db == '0);
  assign extra_bit_c   = (db_prev != '0) && ((db & ~db_prev) != '0);
  assign step_c        = pattern_q[press_count[3:0]];
  // Equality with a one-hot mask also rejects multi-button presses.
  assign step_match_c  = (db == (8'(1) << step_c));
  assign timeout_c     = (tmo_cnt >= TMO_LIM);
  assign seq_len_c     = level[2] ? CNT_W'(16) :
                         level[1] ? CNT_W'(12) :
                         level[0] ? CNT_W'(8)  : CNT_W'(4);

  // State register.
  always_ff @(posedge clk_1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; dropping enable aborts from any state.
  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:       if (enable_rise_c) state_d = S_WAIT_PRESS;
        S_WAIT_PRESS: begin
          // A press in the same cycle as the timeout takes priority.
          if (press_evt_c)    state_d = step_match_c ? S_WAIT_RELEASE : S_FAIL;
          else if (timeout_c) state_d = S_FAIL;
        end
        S_WAIT_RELEASE: begin
          if (extra_bit_c)        state_d = S_FAIL;
          else if (release_evt_c) state_d = (press_count == seq_len_q) ? S_PASS : S_WAIT_PRESS;
        end
        S_PASS, S_FAIL: state_d = state;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    capture_c     = (state == S_IDLE) && (state_d == S_WAIT_PRESS);
    press_count_d = press_count;
    if (capture_c) press_count_d = '0;
    else if ((state == S_WAIT_PRESS) && (state_d == S_WAIT_RELEASE))
      press_count_d = press_count + CNT_W'(1);
    led_d        = (state_d == S_WAIT_RELEASE) ? db_d : '0;
    check_pass_d = (state_d == S_PASS);
    check_fail_d = (state_d == S_FAIL);
  end

  // Output, capture and timeout registers.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      led         <= '0;
      press_count <= '0;
      check_pass  <= 1'b0;
      check_fail  <= 1'b0;
      pattern_q   <= '0;
      seq_len_q   <= '0;
      tmo_cnt     <= '0;
      enable_prev <= 1'b0;
    end else begin
      led         <= led_d;
      press_count <= press_count_d;
      check_pass  <= check_pass_d;
      check_fail  <= check_fail_d;
      enable_prev <= enable;
      if (capture_c) begin
        pattern_q <= pattern_flat;
        seq_len_q <= seq_len_c;
      end
      // Restarts on every entry to WAIT_PRESS, saturates at the limit.
      if ((state_d == S_WAIT_PRESS) && (state != S_WAIT_PRESS)) tmo_cnt <= '0;
      else if ((state == S_WAIT_PRESS) && (tmo_cnt < TMO_LIM)) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule
